// File: rtl/axi_stream_insert_header_if.sv
// Signal bundle for the header-insert block: payload in, header in, stream out.
// Handshake rule on every channel: a beat transfers on the rising edge where
// valid && ready; once valid is high the source holds payload stable until it transfers.
interface axi_stream_insert_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  logic                     valid_in;
  logic [DATA_WD-1:0]       data_in;
  logic [DATA_BYTE_WD-1:0]  keep_in;
  logic                     last_in;
  logic                     ready_in;

  logic                     valid_insert;
  logic [DATA_WD-1:0]       data_insert;
  logic [DATA_BYTE_WD-1:0]  keep_insert;
  logic [BYTE_CNT_WD:0]     byte_insert_cnt;
  logic                     ready_insert;

  logic                     valid_out;
  logic [DATA_WD-1:0]       data_out;
  logic [DATA_BYTE_WD-1:0]  keep_out;
  logic                     last_out;
  logic                     ready_out;

  modport slave (
    input  valid_in, data_in, keep_in, last_in,
    output ready_in,
    input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
    output ready_insert,
    output valid_out, data_out, keep_out, last_out,
    input  ready_out
  );

  modport master (
    output valid_in, data_in, keep_in, last_in,
    input  ready_in,
    output valid_insert, data_insert, keep_insert, byte_insert_cnt,
    input  ready_insert,
    input  valid_out, data_out, keep_out, last_out,
    output ready_out
  );
endinterface

// File: rtl/axi_stream_insert_header.sv
// Prepends the low N bytes of a header beat to one AXI-Stream packet, realigning
// payload bytes across beats and adding a flush beat when the tail spills over.
module axi_stream_insert_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  axi_stream_insert_header_if.slave  bus,
  output logic [1:0]                 state_o
);
  localparam int W  = DATA_BYTE_WD;
  localparam int CW = BYTE_CNT_WD;
  localparam logic [CW:0]   W_N = (CW+1)'(W);
  localparam logic [CW+1:0] W_S = (CW+2)'(W);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, FLUSH = 2'd2} state_t;

  function automatic logic [CW:0] lead_ones(input logic [W-1:0] k);
    logic [CW:0] cnt;
    logic        run;
    cnt = '0;
    run = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      if (run && k[i]) cnt = cnt + (CW+1)'(1);
      else             run = 1'b0;
    end
    return cnt;
  endfunction

  function automatic logic [W-1:0] top_mask(input logic [CW+1:0] k);
    return ~({W{1'b1}} >> k);
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [W-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_t              state_q, state_d;
  logic [CW:0]         n_q, n_d;
  logic [DATA_WD-1:0]  r_q, r_d;
  logic [CW+1:0]       fcnt_q, fcnt_d;
  logic                valid_q, valid_d, last_q, last_d;
  logic [DATA_WD-1:0]  data_q, data_d;
  logic [W-1:0]        keep_q, keep_d;

  logic                adv, hs_hdr, hs_in, fits;
  logic [CW:0]         n_sat, lead;
  logic [CW+1:0]       sum;
  logic [DATA_WD-1:0]  masked;
  logic                unused_keep_insert;

  assign adv              = !valid_q || bus.ready_out;
  assign bus.ready_insert = rst_n && adv && (state_q == IDLE);
  assign bus.ready_in     = rst_n && adv && (state_q == DATA);
  assign hs_hdr           = bus.valid_insert && bus.ready_insert;
  assign hs_in            = bus.valid_in && bus.ready_in;

  // The header byte count is authoritative; keep_insert is carried for completeness only.
  assign unused_keep_insert = ^bus.keep_insert;
  assign n_sat  = (bus.byte_insert_cnt > W_N) ? W_N : bus.byte_insert_cnt;
  assign lead   = lead_ones(bus.keep_in);
  assign sum    = {1'b0, n_q} + {1'b0, lead};
  assign fits   = (sum <= W_S);
  assign masked = bus.data_in & byte_mask(bus.keep_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs_hdr) state_d = DATA;
      DATA:    if (hs_in && bus.last_in) state_d = fits ? IDLE : FLUSH;
      FLUSH:   if (adv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Residual is held left-aligned so a beat is simply residual OR payload shifted right by N bytes.
  always_comb begin
    n_d     = n_q;
    r_d     = r_q;
    fcnt_d  = fcnt_q;
    valid_d = adv ? 1'b0 : valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (hs_hdr) begin
        n_d = n_sat;
        r_d = bus.data_insert << {W_N - n_sat, 3'b000};
      end
      DATA: if (hs_in) begin
        valid_d = 1'b1;
        data_d  = r_q | (masked >> {n_q, 3'b000});
        r_d     = masked << {W_N - n_q, 3'b000};
        fcnt_d  = sum - W_S;
        last_d  = bus.last_in && fits;
        keep_d  = (bus.last_in && fits) ? top_mask(sum) : {W{1'b1}};
      end
      FLUSH: if (adv) begin
        valid_d = 1'b1;
        data_d  = r_q;
        keep_d  = top_mask(fcnt_q);
        last_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= '0;
      r_q     <= '0;
      fcnt_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      n_q     <= n_d;
      r_q     <= r_d;
      fcnt_q  <= fcnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  assign bus.keep_out  = keep_q;
  assign bus.last_out  = last_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Directed bench for axi_stream_insert_header (W=4): per-scenario tasks compare
// captured output beats against hand-computed expected beats.
`timescale 1ns/1ps
module tb_axi_stream_insert_header;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 2;
  localparam int EW = DW + BW + 1;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_o;

  axi_stream_insert_header_if #(.DATA_WD(DW)) bus();

  axi_stream_insert_header #(.DATA_WD(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  int compared = 0;
  int errors   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] rx_q[$];
  bit            toggle_ready = 1'b0;
  bit            stall_pend   = 1'b0;
  logic [EW-1:0] stall_val;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sink ready: changes just after each rising edge, so it is stable at the negedge.
  initial begin
    bus.ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.ready_out = toggle_ready ? ~bus.ready_out : 1'b1;
    end
  end

  // Output monitor: captures transferred beats and checks hold-while-stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) begin
          compared++;
          if (!bus.valid_out || {bus.data_out, bus.keep_out, bus.last_out} !== stall_val) begin
            errors++;
            $display("FAIL stall_hold got v=%0b beat=%h want v=1 beat=%h", bus.valid_out,
                     {bus.data_out, bus.keep_out, bus.last_out}, stall_val);
          end
        end
        if (bus.valid_out && bus.ready_out) rx_q.push_back({bus.data_out, bus.keep_out, bus.last_out});
        stall_pend = bus.valid_out && !bus.ready_out;
        stall_val  = {bus.data_out, bus.keep_out, bus.last_out};
      end
    end
  end

  // driver tasks
  task automatic idle_inputs();
    bus.valid_in        = 1'b0;
    bus.data_in         = '0;
    bus.keep_in         = '0;
    bus.last_in         = 1'b0;
    bus.valid_insert    = 1'b0;
    bus.data_insert     = '0;
    bus.keep_insert     = '0;
    bus.byte_insert_cnt = '0;
  endtask

  task automatic send_hdr(input logic [DW-1:0] d, input logic [CW:0] n);
    bit ok;
    int c;
    bus.valid_insert    = 1'b1;
    bus.data_insert     = d;
    bus.byte_insert_cnt = n;
    bus.keep_insert     = BW'((32'd1 << n) - 32'd1);
    c = 0;
    do begin
      @(negedge clk);
      ok = bus.ready_insert;
      @(posedge clk);
      c++;
    end while (!ok && c < 200);
    if (!ok) begin
      compared++;
      errors++;
      $display("FAIL hdr_timeout got ready_insert=0 want 1 within 200 cycles");
    end
    #1 bus.valid_insert = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
    bit ok;
    int c;
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    bus.keep_in  = k;
    bus.last_in  = l;
    c = 0;
    do begin
      @(negedge clk);
      ok = bus.ready_in;
      @(posedge clk);
      c++;
    end while (!ok && c < 200);
    if (!ok) begin
      compared++;
      errors++;
      $display("FAIL beat_timeout got ready_in=0 want 1 within 200 cycles");
    end
    #1 bus.valid_in = 1'b0;
  endtask

  task automatic drive_stream1(input logic [DW-1:0] last_d, input logic [BW-1:0] last_k);
    send_hdr(32'hAABBCCDD, 3'd2);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b0);
    send_beat(last_d, last_k, 1'b1);
  endtask

  task automatic wait_out();
    for (int c = 0; c < 80 && rx_q.size() < exp_q.size(); c++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic start_test();
    exp_q.delete();
    rx_q.delete();
    @(posedge clk);
    #1;
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    compared++;
    if ({bus.valid_out, bus.last_out, bus.data_out, bus.keep_out, bus.ready_in, bus.ready_insert} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b l=%0b d=%h k=%b rin=%0b rins=%0b want all 0",
               bus.valid_out, bus.last_out, bus.data_out, bus.keep_out, bus.ready_in, bus.ready_insert);
    end
    compared++;
    if (state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got %0d want 0", state_o);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    start_test();
    exp_q.push_back({32'hCCDD1122, 4'b1111, 1'b0});
    exp_q.push_back({32'h33445566, 4'b1111, 1'b0});
    exp_q.push_back({32'h778899AA, 4'b1111, 1'b1});
    send_hdr(32'hAABBCCDD, 3'd2);
    @(negedge clk);
    compared++;
    if (bus.ready_insert !== 1'b0 || state_o !== 2'd1) begin
      errors++;
      $display("FAIL basic_in_data got ready_insert=%0b state=%0d want 0 / 1", bus.ready_insert, state_o);
    end
    @(posedge clk);
    #1;
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b0);
    send_beat(32'h99AA0000, 4'b1100, 1'b1);
    wait_out();
    compared++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      compared++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_beat%0d got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_flush();
    start_test();
    exp_q.push_back({32'hCCDD1122, 4'b1111, 1'b0});
    exp_q.push_back({32'h33445566, 4'b1111, 1'b0});
    exp_q.push_back({32'h778899AA, 4'b1111, 1'b0});
    exp_q.push_back({32'hBB000000, 4'b1000, 1'b1});
    drive_stream1(32'h99AABB00, 4'b1110);
    @(negedge clk);
    compared++;
    if (bus.ready_in !== 1'b0 || state_o !== 2'd2) begin
      errors++;
      $display("FAIL flush_ready_in got ready_in=%0b state=%0d want 0 / 2", bus.ready_in, state_o);
    end
    wait_out();
    compared++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL flush_count got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      compared++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL flush_beat%0d got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_n0();
    start_test();
    send_hdr(32'hFFFFFFFF, 3'd0);
    send_beat(32'h12345678, 4'b1111, 1'b1);
    @(negedge clk);
    compared++;
    if ({bus.valid_out, bus.data_out, bus.keep_out, bus.last_out} !== {1'b1, 32'h12345678, 4'b1111, 1'b1}) begin
      errors++;
      $display("FAIL n0_latency got v=%0b d=%h k=%b l=%0b want v=1 d=12345678 k=1111 l=1",
               bus.valid_out, bus.data_out, bus.keep_out, bus.last_out);
    end
    exp_q.push_back({32'h12345678, 4'b1111, 1'b1});
    wait_out();
    compared++;
    if (rx_q.size() != 1) begin
      errors++;
      $display("FAIL n0_count got %0d want 1", rx_q.size());
    end
  endtask

  task automatic test_n4();
    start_test();
    exp_q.push_back({32'h01020304, 4'b1111, 1'b0});
    exp_q.push_back({32'hA1000000, 4'b1000, 1'b1});
    send_hdr(32'h01020304, 3'd4);
    send_beat(32'hA1A2A3A4, 4'b1000, 1'b1);
    wait_out();
    compared++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL n4_count got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      compared++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL n4_beat%0d got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    start_test();
    exp_q.push_back({32'hCCDD1122, 4'b1111, 1'b0});
    exp_q.push_back({32'h33445566, 4'b1111, 1'b0});
    exp_q.push_back({32'h778899AA, 4'b1111, 1'b1});
    toggle_ready = 1'b1;
    drive_stream1(32'h99AA0000, 4'b1100);
    wait_out();
    toggle_ready = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      compared++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_beat%0d got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    start_test();
    exp_q.push_back({32'hEE010203, 4'b1111, 1'b0});
    exp_q.push_back({32'h04050607, 4'b1111, 1'b1});
    exp_q.push_back({32'hA0B0C0DE, 4'b1111, 1'b0});
    exp_q.push_back({32'hAD000000, 4'b1000, 1'b1});
    send_hdr(32'h000000EE, 3'd1);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060700, 4'b1110, 1'b1);
    send_hdr(32'h00A0B0C0, 3'd3);
    send_beat(32'hDEADBEEF, 4'b1100, 1'b1);
    wait_out();
    compared++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      compared++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    start_test();
    send_hdr(32'hAABBCCDD, 3'd2);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({bus.valid_out, bus.last_out, bus.data_out, bus.keep_out, bus.ready_in, bus.ready_insert} !== '0
        || state_o !== 2'd0) begin
      errors++;
      $display("FAIL midreset_outputs got v=%0b l=%0b d=%h k=%b rin=%0b rins=%0b st=%0d want all 0",
               bus.valid_out, bus.last_out, bus.data_out, bus.keep_out, bus.ready_in, bus.ready_insert, state_o);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_test();
    exp_q.push_back({32'hCCDD1122, 4'b1111, 1'b0});
    exp_q.push_back({32'h33445566, 4'b1111, 1'b0});
    exp_q.push_back({32'h778899AA, 4'b1111, 1'b1});
    drive_stream1(32'h99AA0000, 4'b1100);
    wait_out();
    compared++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midreset_count got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      compared++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_beat%0d got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_n0();
    test_n4();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end
endmodule
